pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer. Feeds pc_plus4 into input a of the 32-bit next-PC 2:1 mux, and receives that mux's output as next_pc. redirect is the same signal that drives the mux select, so the mux selects the branch target on b. The block issues single-outstanding requests to instruction memory and delivers fetched instructions to decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, increment used to form pc_plus4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
next_pc  input  32  output of the next-PC 2:1 mux.
redirect  input  1  branch/jump taken; also the next-PC mux select.
stall  input  1  downstream hold; blocks issue of new fetches.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address.
imem_ack  input  1  memory accepted request; imem_rdata valid this cycle.
imem_rdata  input  32  fetched instruction word.
pc  output  32  current PC register.
pc_plus4  output  32  pc + PC_STEP, combinational, mod 2^32; drives mux input a.
instr  output  32  registered fetched instruction.
instr_valid  output  1  one-cycle pulse; instr and instr_pc are valid.
instr_pc  output  32  address the delivered instr was fetched from.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; redir_pc=0; state=IDLE.
  - imem_req=0, instr=0, instr_valid=0, instr_pc=0.
  - imem_req falls immediately on assertion, even mid-request.
- imem_addr = pc in IDLE/REQ, and the captured pc in DROP. Held stable while imem_req=1 until imem_ack is sampled high.
- Handshake: a raised imem_req is never withdrawn before ack. Only one request is outstanding. imem_ack is ignored when imem_req=0.
- FSM states:
  - IDLE, imem_req=0:
    - redirect: pc<=next_pc.
    - next state is REQ if !stall, else IDLE.
  - REQ, imem_req=1:
    - ack & !redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1 (next cycle), pc<=next_pc (=pc_plus4). Go to REQ if !stall, else IDLE.
    - ack & redirect: data discarded, instr_valid stays 0, pc<=next_pc. Go to REQ if !stall, else IDLE.
    - !ack & redirect: redir_pc<=next_pc, go to DROP. Request stays asserted at old address.
    - !ack & !redirect: hold.
  - DROP, imem_req=1, old address:
    - redirect again: redir_pc<=next_pc (latest wins).
    - ack: data discarded, pc<=redirect target. The target is next_pc if redirect is asserted this cycle, else redir_pc. Go to REQ if !stall, else IDLE.
- Latency: one instruction per cycle when memory acks in the same cycle as the request. instr_valid follows the ack by 1 cycle.
- stall never suppresses an instr_valid pulse already earned. It only affects the transition out of an ack or IDLE.
- PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag. No alignment enforcement.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] (+1 per instr_valid pulse) and drop_cnt[31:0] (+1 per discarded ack). Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent, with no other behaviour change.

Test Plan:
- RESET_PC=0, imem_ack tied 1, stall=0, release rst_n -> imem_addr 0x0,0x4,0x8 on consecutive cycles. instr_valid high each cycle from 2nd cycle, with instr_pc matching.
- Request at 0x4, imem_ack delayed 3 cycles -> imem_req=1 and imem_addr=0x4 held 3 cycles, then exactly one instr_valid with instr_pc=0x4.
- Outstanding request at 0x8, redirect=1 with next_pc=0x100 for one cycle, ack 2 cycles later -> no instr_valid. Next imem_addr=0x100, pc=0x100.
- redirect=1, next_pc=0x200 in the same cycle as ack at 0xC -> data dropped, next imem_addr=0x200. With FETCH_PERF_CNT_EN, drop_cnt=1.
- stall=1 during an outstanding request at 0x10, ack after 2 cycles -> instr_valid pulses once, imem_req=0 until stall=0, then imem_addr=0x14.
- rst_n=0 mid-request at 0x20 -> imem_req=0 immediately (same cycle, no clock), pc=RESET_PC. After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction-fetch sequencer.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt/drop_cnt outputs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t      state;
  logic [31:0] redir_pc;
  assign pc_plus4  = pc + PC_STEP;
  assign imem_req  = state != IDLE;
  // pc only moves on ack or in IDLE, so it still holds the outstanding address in DROP
  assign imem_addr = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      redir_pc    <= 32'h0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      instr_pc    <= 32'h0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (redirect) pc <= next_pc;
          state <= stall ? IDLE : REQ;
        end
        REQ: begin
          if (imem_ack) begin
            if (!redirect) begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
            end
            pc    <= next_pc;
            state <= stall ? IDLE : REQ;
          end else if (redirect) begin
            redir_pc <= next_pc;
            state    <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            pc    <= redirect ? next_pc : redir_pc;
            state <= stall ? IDLE : REQ;
          end else if (redirect) begin
            redir_pc <= next_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic drop_ev;
  assign drop_ev = imem_ack && ((state == REQ && redirect) || state == DROP);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      drop_cnt  <= 32'h0;
    end else begin
      if (instr_valid && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop_ev && drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven cycle vectors with a delivery scoreboard for pc_fetch_unit.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc, tgt = 32'h0;
  logic        redirect = 1'b0, stall = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc, pc_plus4, instr, instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, drop_cnt;
`endif
  int pass_cnt = 0, total_cnt = 0, pulses = 0;
  typedef struct {
    logic        ack;
    logic        redir;
    logic        stl;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        dlv;
  } vec_t;
  vec_t        vecs[$];
  logic [31:0] q_instr[$], q_pc[$];
  assign next_pc = redirect ? tgt : pc_plus4;
  always #5 clk = ~clk;
  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect(redirect), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic add(input logic ack, input logic redir, input logic stl, input logic [31:0] target,
                     input logic req, input logic [31:0] addr, input logic dlv);
    vec_t v;
    v.ack = ack; v.redir = redir; v.stl = stl; v.target = target;
    v.req = req; v.addr = addr; v.dlv = dlv;
    vecs.push_back(v);
  endtask
  task automatic chk_valid();
    logic [31:0] ei, ep;
    if (instr_valid) begin
      pulses++;
      if (q_instr.size() == 0) chk("unexpected_instr_valid", 32'd1, 32'd0);
      else begin
        ei = q_instr.pop_front();
        ep = q_pc.pop_front();
        chk("instr", instr, ei);
        chk("instr_pc", instr_pc, ep);
      end
    end
  endtask
  initial begin
    //   ack redir stall target          req addr            dlv
    add(1, 0, 0, 32'h0,          0, 32'h0000_0000, 0);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0000, 1);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0004, 1);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0008, 0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0008, 0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0008, 0);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0008, 1);
    add(0, 1, 0, 32'h100,        1, 32'h0000_000C, 0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_000C, 0);
    add(1, 0, 0, 32'h0,          1, 32'h0000_000C, 0);
    add(1, 1, 0, 32'h200,        1, 32'h0000_0100, 0);
    add(0, 0, 1, 32'h0,          1, 32'h0000_0200, 0);
    add(0, 0, 1, 32'h0,          1, 32'h0000_0200, 0);
    add(1, 0, 1, 32'h0,          1, 32'h0000_0200, 1);
    add(1, 0, 1, 32'h0,          0, 32'h0000_0204, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0000_0204, 0);
    add(0, 1, 0, 32'h300,        1, 32'h0000_0204, 0);
    add(0, 1, 0, 32'h400,        1, 32'h0000_0204, 0);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0204, 0);
    add(0, 1, 0, 32'h500,        1, 32'h0000_0400, 0);
    add(1, 1, 0, 32'h600,        1, 32'h0000_0400, 0);
    add(1, 0, 1, 32'h0,          1, 32'h0000_0600, 1);
    add(0, 1, 0, 32'hFFFF_FFFC,  0, 32'h0000_0604, 0);
    add(1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 1);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0000, 1);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0004, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      chk_valid();
      chk($sformatf("req_r%0d", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      chk($sformatf("addr_r%0d", i), imem_addr, vecs[i].addr);
      chk($sformatf("pc_r%0d", i), pc, vecs[i].addr);
      chk($sformatf("pc_plus4_r%0d", i), pc_plus4, vecs[i].addr + 32'd4);
      imem_ack   = vecs[i].ack;
      redirect   = vecs[i].redir;
      stall      = vecs[i].stl;
      tgt        = vecs[i].target;
      imem_rdata = 32'hC0DE_0000 + i;
      if (vecs[i].dlv) begin
        q_instr.push_back(32'hC0DE_0000 + i);
        q_pc.push_back(vecs[i].addr);
      end
      @(negedge clk);
    end
    chk_valid();
    chk("pulse_count", pulses, 32'd7);
    chk("scoreboard_empty", q_instr.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd7);
    chk("drop_cnt", drop_cnt, 32'd4);
`endif
    imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreq_rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("midreq_rst_pc", pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_req", {31'b0, imem_req}, 32'd0);
    chk("post_rst_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_req1", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr1", imem_addr, 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
